// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet source.
// Latency: n/a (package). Backpressure: n/a.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } tx_state_t;

    typedef struct packed {
        logic [5:0] len;
        logic [1:0] addr;
    } hdr_t;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         MAX_LEN      = 63;

    function automatic hdr_t pack_header(input logic [5:0] len, input logic [1:0] addr);
        hdr_t h;
        h.len  = len;
        h.addr = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_tx_fifo.sv
// Synchronous DEPTH x 8 payload FIFO with head and head+1 peek ports.
// Latency: write visible at head one cycle after wr_en; count/full registered.
// Backpressure: writes when full are dropped; reads when empty are ignored.
module router_tx_fifo #(
    parameter int DEPTH = 64,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic [7:0]    rd_data_nxt,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;
    logic [CW-1:0] count_nxt;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (count == '0);
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign count_nxt   = count + CW'(wr_ok) - CW'(rd_ok);
    assign rd_data     = mem[rd_ptr];
    // Lets the sender preload the following byte in the same cycle it pops the head.
    assign rd_data_nxt = mem[ptr_inc(rd_ptr)];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Framed packet source: header {len,addr}, buffered payload, then XOR parity byte.
// Latency: header on data_out the cycle after start is accepted; one byte per cycle.
// Backpressure: busy high holds data_out, pkt_valid and state, with no buffer pop.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] pkt_len,
    input  logic       corrupt_parity,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       cmd_err,
    output logic [6:0] buf_count,
    output logic       buf_full
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] rem_q, rem_nxt;
    logic [7:0]       acc_q, acc_nxt;
    logic             corrupt_q, corrupt_nxt;
    logic [7:0]       dout_nxt;
    logic             vld_nxt, act_nxt, done_nxt, err_nxt;
    logic             pop;
    logic             start_ok;
    logic [7:0]       fifo_head;
    logic [7:0]       fifo_head_nxt;
    logic             fifo_empty;

    router_tx_fifo #(
        .DEPTH (DEPTH),
        .CW    (7)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (pop),
        .rd_data     (fifo_head),
        .rd_data_nxt (fifo_head_nxt),
        .count       (buf_count),
        .full        (buf_full),
        .empty       (fifo_empty)
    );

    assign start_ok = (dest_addr != ADDR_INVALID) && (buf_count >= {1'b0, pkt_len});

    always_comb begin
        state_nxt   = state;
        rem_nxt     = rem_q;
        acc_nxt     = acc_q;
        corrupt_nxt = corrupt_q;
        dout_nxt    = data_out;
        vld_nxt     = pkt_valid;
        act_nxt     = tx_active;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        pop         = 1'b0;
        case (state)
            ST_IDLE: begin
                dout_nxt = '0;
                vld_nxt  = 1'b0;
                act_nxt  = 1'b0;
                if (start) begin
                    if (start_ok) begin
                        rem_nxt     = pkt_len;
                        corrupt_nxt = corrupt_parity;
                        acc_nxt     = pack_header(pkt_len, dest_addr);
                        dout_nxt    = pack_header(pkt_len, dest_addr);
                        vld_nxt     = 1'b1;
                        act_nxt     = 1'b1;
                        state_nxt   = ST_HEADER;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_HEADER: begin
                if (!busy) begin
                    if (rem_q != '0) begin
                        dout_nxt  = fifo_head;
                        state_nxt = ST_PAYLOAD;
                    end else begin
                        dout_nxt  = acc_q ^ {7'b0, corrupt_q};
                        vld_nxt   = 1'b0;
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!busy) begin
                    pop     = !fifo_empty;
                    acc_nxt = acc_q ^ data_out;
                    rem_nxt = rem_q - 1'b1;
                    if (rem_q == LEN_W'(1)) begin
                        dout_nxt  = acc_nxt ^ {7'b0, corrupt_q};
                        vld_nxt   = 1'b0;
                        state_nxt = ST_PARITY;
                    end else begin
                        dout_nxt = fifo_head_nxt;
                    end
                end
            end
            ST_PARITY: begin
                if (!busy) begin
                    dout_nxt  = '0;
                    vld_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                dout_nxt  = '0;
                vld_nxt   = 1'b0;
                act_nxt   = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rem_q     <= '0;
            acc_q     <= '0;
            corrupt_q <= 1'b0;
            data_out  <= '0;
            pkt_valid <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rem_q     <= rem_nxt;
            acc_q     <= acc_nxt;
            corrupt_q <= corrupt_nxt;
            data_out  <= dout_nxt;
            pkt_valid <= vld_nxt;
            tx_active <= act_nxt;
            done      <= done_nxt;
            cmd_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: directed scenarios plus randomized packets against a queue model.
// Latency: n/a. Backpressure: busy patterns per cycle.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pkt_len;
    logic       corrupt_parity;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid, tx_active, done, cmd_err, buf_full;
    logic [6:0] buf_count;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mbuf[$];
    logic [7:0] exp_dat[$];
    logic       exp_vld[$], exp_done[$], exp_act[$];
    logic [7:0] obs_dat[$];
    logic       obs_vld[$], obs_done[$], obs_act[$], obs_err[$];
    logic       bq[$];
    logic       wq_en[$];
    logic [7:0] wq_dat[$];
    logic       rand_start;

    always #5 clk = ~clk;

    router_pkt_tx #(.DEPTH(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .start          (start),
        .dest_addr      (dest_addr),
        .pkt_len        (pkt_len),
        .corrupt_parity (corrupt_parity),
        .busy           (busy),
        .data_out       (data_out),
        .pkt_valid      (pkt_valid),
        .tx_active      (tx_active),
        .done           (done),
        .cmd_err        (cmd_err),
        .buf_count      (buf_count),
        .buf_full       (buf_full)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
        if (mbuf.size() < 64) mbuf.push_back(b);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mbuf.delete();
    endtask

    task automatic clear_plan;
        bq.delete();
        wq_en.delete();
        wq_dat.delete();
        for (int c = 0; c < 400; c++) begin
            bq.push_back(1'b0);
            wq_en.push_back(1'b0);
            wq_dat.push_back(8'h00);
        end
        rand_start = 1'b0;
    endtask

    // Expected per-cycle trace: each frame byte shown until an edge without busy, then GAP and IDLE.
    task automatic model_pkt(input logic [1:0] a, input logic [5:0] l, input logic cor);
        logic [7:0] frame[$];
        logic [7:0] par;
        int i, c;
        exp_dat.delete(); exp_vld.delete(); exp_done.delete(); exp_act.delete();
        frame.push_back(8'(int'(l) * 4 + int'(a)));
        for (int k = 0; k < int'(l); k++) frame.push_back(mbuf.pop_front());
        par = 8'h00;
        foreach (frame[k]) par = par ^ frame[k];
        par[0] = par[0] ^ cor;
        frame.push_back(par);
        i = 0;
        c = 0;
        while (i < frame.size()) begin
            exp_dat.push_back(frame[i]);
            exp_vld.push_back(i != frame.size() - 1);
            exp_done.push_back(1'b0);
            exp_act.push_back(1'b1);
            if (!bq[c]) i++;
            c++;
        end
        exp_dat.push_back(8'h00); exp_vld.push_back(1'b0); exp_done.push_back(1'b1); exp_act.push_back(1'b1);
        exp_dat.push_back(8'h00); exp_vld.push_back(1'b0); exp_done.push_back(1'b0); exp_act.push_back(1'b0);
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic cor);
        obs_dat.delete(); obs_vld.delete(); obs_done.delete(); obs_act.delete(); obs_err.delete();
        dest_addr      = a;
        pkt_len        = l;
        corrupt_parity = cor;
        start          = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < exp_dat.size(); c++) begin
            obs_dat.push_back(data_out);
            obs_vld.push_back(pkt_valid);
            obs_done.push_back(done);
            obs_act.push_back(tx_active);
            obs_err.push_back(cmd_err);
            busy    = bq[c];
            wr_en   = wq_en[c];
            wr_data = wq_dat[c];
            if (wq_en[c]) mbuf.push_back(wq_dat[c]);
            if (rand_start && c < exp_dat.size() - 1) begin
                start     = 1'($urandom_range(0, 1));
                dest_addr = 2'b11;
            end
            tick();
            start = 1'b0;
        end
        busy  = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_chk++;
        if ({data_out, pkt_valid, tx_active, done, cmd_err, buf_count, buf_full} !== 20'h0)
            $display("FAIL reset_state dat=%h vld=%b act=%b done=%b err=%b cnt=%0d full=%b required all zero",
                     data_out, pkt_valid, tx_active, done, cmd_err, buf_count, buf_full);
        else n_pass++;
        reset = 1'b0;
        mbuf.delete();
    endtask

    task automatic test_basic;
        clear_plan();
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        model_pkt(2'd1, 6'd3, 1'b0);
        run_pkt(2'd1, 6'd3, 1'b0);
        for (int c = 0; c < exp_dat.size(); c++) begin
            n_chk++;
            if (obs_dat[c] !== exp_dat[c] || obs_vld[c] !== exp_vld[c] || obs_done[c] !== exp_done[c] || obs_act[c] !== exp_act[c])
                $display("FAIL basic cyc%0d got dat=%h vld=%b done=%b act=%b required dat=%h vld=%b done=%b act=%b",
                         c, obs_dat[c], obs_vld[c], obs_done[c], obs_act[c], exp_dat[c], exp_vld[c], exp_done[c], exp_act[c]);
            else n_pass++;
        end
        n_chk++;
        if (buf_count !== 7'd0) $display("FAIL basic_count got %0d required 0", buf_count);
        else n_pass++;
    endtask

    task automatic test_zero_len;
        clear_plan();
        model_pkt(2'd2, 6'd0, 1'b0);
        run_pkt(2'd2, 6'd0, 1'b0);
        for (int c = 0; c < exp_dat.size(); c++) begin
            n_chk++;
            if (obs_dat[c] !== exp_dat[c] || obs_vld[c] !== exp_vld[c] || obs_done[c] !== exp_done[c] || obs_act[c] !== exp_act[c])
                $display("FAIL zero_len cyc%0d got dat=%h vld=%b done=%b act=%b required dat=%h vld=%b done=%b act=%b",
                         c, obs_dat[c], obs_vld[c], obs_done[c], obs_act[c], exp_dat[c], exp_vld[c], exp_done[c], exp_act[c]);
            else n_pass++;
        end
    endtask

    task automatic test_cmd_err;
        logic [1:0] addrs [2];
        logic [5:0] lens  [2];
        addrs[0] = 2'd3; lens[0] = 6'd0;
        addrs[1] = 2'd0; lens[1] = 6'd5;
        wr_byte(8'hA1); wr_byte(8'hB2);
        for (int k = 0; k < 2; k++) begin
            dest_addr = addrs[k];
            pkt_len   = lens[k];
            start     = 1'b1;
            tick();
            start = 1'b0;
            n_chk++;
            if (cmd_err !== 1'b1 || pkt_valid !== 1'b0 || tx_active !== 1'b0)
                $display("FAIL cmd_err_%0d got err=%b vld=%b act=%b required err=1 vld=0 act=0", k, cmd_err, pkt_valid, tx_active);
            else n_pass++;
            tick();
            n_chk++;
            if (cmd_err !== 1'b0 || pkt_valid !== 1'b0 || buf_count !== 7'd2)
                $display("FAIL cmd_err_after_%0d got err=%b vld=%b cnt=%0d required err=0 vld=0 cnt=2", k, cmd_err, pkt_valid, buf_count);
            else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_back_pressure;
        clear_plan();
        bq[2] = 1'b1; bq[3] = 1'b1; bq[4] = 1'b1;
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        model_pkt(2'd1, 6'd3, 1'b0);
        run_pkt(2'd1, 6'd3, 1'b0);
        for (int c = 0; c < exp_dat.size(); c++) begin
            n_chk++;
            if (obs_dat[c] !== exp_dat[c] || obs_vld[c] !== exp_vld[c] || obs_done[c] !== exp_done[c] || obs_act[c] !== exp_act[c])
                $display("FAIL back_pressure cyc%0d got dat=%h vld=%b done=%b act=%b required dat=%h vld=%b done=%b act=%b",
                         c, obs_dat[c], obs_vld[c], obs_done[c], obs_act[c], exp_dat[c], exp_vld[c], exp_done[c], exp_act[c]);
            else n_pass++;
        end
    endtask

    task automatic test_corrupt;
        clear_plan();
        wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33);
        model_pkt(2'd1, 6'd3, 1'b1);
        run_pkt(2'd1, 6'd3, 1'b1);
        for (int c = 0; c < exp_dat.size(); c++) begin
            n_chk++;
            if (obs_dat[c] !== exp_dat[c] || obs_vld[c] !== exp_vld[c] || obs_done[c] !== exp_done[c])
                $display("FAIL corrupt cyc%0d got dat=%h vld=%b done=%b required dat=%h vld=%b done=%b",
                         c, obs_dat[c], obs_vld[c], obs_done[c], exp_dat[c], exp_vld[c], exp_done[c]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        wr_byte(8'h44); wr_byte(8'h55); wr_byte(8'h66);
        dest_addr = 2'd0; pkt_len = 6'd3; corrupt_parity = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mbuf.delete();
        n_chk++;
        if (pkt_valid !== 1'b0 || data_out !== 8'h00 || buf_count !== 7'd0 || tx_active !== 1'b0)
            $display("FAIL reset_mid got vld=%b dat=%h cnt=%0d act=%b required 0 00 0 0", pkt_valid, data_out, buf_count, tx_active);
        else n_pass++;
        clear_plan();
        wr_byte(8'hA5); wr_byte(8'h5A);
        model_pkt(2'd2, 6'd2, 1'b0);
        run_pkt(2'd2, 6'd2, 1'b0);
        for (int c = 0; c < exp_dat.size(); c++) begin
            n_chk++;
            if (obs_dat[c] !== exp_dat[c] || obs_vld[c] !== exp_vld[c] || obs_done[c] !== exp_done[c] || obs_act[c] !== exp_act[c])
                $display("FAIL reset_fresh cyc%0d got dat=%h vld=%b done=%b act=%b required dat=%h vld=%b done=%b act=%b",
                         c, obs_dat[c], obs_vld[c], obs_done[c], obs_act[c], exp_dat[c], exp_vld[c], exp_done[c], exp_act[c]);
            else n_pass++;
        end
    endtask

    task automatic test_full;
        for (int k = 0; k < 66; k++) wr_byte(8'(k));
        n_chk++;
        if (buf_count !== 7'd64 || buf_full !== 1'b1)
            $display("FAIL full got cnt=%0d full=%b required cnt=64 full=1", buf_count, buf_full);
        else n_pass++;
        do_reset();
        n_chk++;
        if (buf_count !== 7'd0 || buf_full !== 1'b0)
            $display("FAIL flush got cnt=%0d full=%b required cnt=0 full=0", buf_count, buf_full);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [1:0] a;
        logic [5:0] l;
        logic       cor;
        int         room, nw;
        for (int it = 0; it < 10; it++) begin
            clear_plan();
            room = 40 - mbuf.size();
            if (room < 0) room = 0;
            for (int k = $urandom_range(0, room); k > 0; k--) wr_byte(8'($urandom));
            a   = 2'($urandom_range(0, 3));
            l   = 6'($urandom_range(0, mbuf.size() + 2));
            cor = 1'($urandom_range(0, 1));
            nw  = 0;
            for (int c = 0; c < 150; c++) begin
                bq[c] = ($urandom_range(0, 3) == 0);
                if (nw < 20 && $urandom_range(0, 3) == 0) begin
                    wq_en[c]  = 1'b1;
                    wq_dat[c] = 8'($urandom);
                    nw++;
                end
            end
            rand_start = 1'b1;
            if (a == 2'd3 || mbuf.size() < int'(l)) begin
                dest_addr = a; pkt_len = l; start = 1'b1;
                tick();
                start = 1'b0;
                n_chk++;
                if (cmd_err !== 1'b1 || pkt_valid !== 1'b0 || buf_count !== 7'(mbuf.size()))
                    $display("FAIL rand_reject it%0d got err=%b vld=%b cnt=%0d required err=1 vld=0 cnt=%0d",
                             it, cmd_err, pkt_valid, buf_count, mbuf.size());
                else n_pass++;
                tick();
            end else begin
                model_pkt(a, l, cor);
                run_pkt(a, l, cor);
                for (int c = 0; c < exp_dat.size(); c++) begin
                    n_chk++;
                    if (obs_dat[c] !== exp_dat[c] || obs_vld[c] !== exp_vld[c] || obs_done[c] !== exp_done[c] ||
                        obs_act[c] !== exp_act[c] || obs_err[c] !== 1'b0)
                        $display("FAIL rand it%0d cyc%0d got dat=%h vld=%b done=%b act=%b err=%b required dat=%h vld=%b done=%b act=%b err=0",
                                 it, c, obs_dat[c], obs_vld[c], obs_done[c], obs_act[c], obs_err[c],
                                 exp_dat[c], exp_vld[c], exp_done[c], exp_act[c]);
                    else n_pass++;
                end
                n_chk++;
                if (buf_count !== 7'(mbuf.size()))
                    $display("FAIL rand_count it%0d got %0d required %0d", it, buf_count, mbuf.size());
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0;
        dest_addr = 2'd0; pkt_len = 6'd0; corrupt_parity = 1'b0; busy = 1'b0;
        rand_start = 1'b0;
        test_reset();
        test_basic();
        test_zero_len();
        test_cmd_err();
        test_back_pressure();
        test_corrupt();
        test_reset_mid();
        test_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet source for the 1x3 router: it takes a destination address, a payload length and payload bytes from the host, and emits a framed packet on the router's input interface. The frame is a header byte, then payload bytes, then a parity byte. The block honours the router's `busy` back-pressure. It sits on the host side of the router input port, both as the production source and as the bench stimulus driver for error-injection tests.

## Interface
Parameters:
- `DEPTH`, 64, payload buffer entries; must be ≥ 63, the maximum packet length.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high; the clock and reset are the only clocking inputs.
- `wr_en`  in  1  write one payload byte into the buffer.
- `wr_data`  in  8  payload byte.
- `start`  in  1  request to send one packet.
- `dest_addr`  in  2  destination port 0..2; the value 3 is illegal.
- `pkt_len`  in  6  payload byte count, 0..63.
- `corrupt_parity`  in  1  when set, bit 0 of the emitted parity is inverted; latched at start.
- `busy`  in  1  router back-pressure; while it is high the current byte is held.
- `data_out`  out  8  byte to the router.
- `pkt_valid`  out  1  high for header and payload bytes, low for the parity byte and when idle.
- `tx_active`  out  1  high from start acceptance until the GAP state is left.
- `done`  out  1  one-cycle pulse when the parity byte has been accepted.
- `cmd_err`  out  1  one-cycle pulse when a start is rejected.
- `buf_count`  out  7  number of bytes in the buffer.
- `buf_full`  out  1  the buffer holds DEPTH bytes.

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- **Start acceptance.** In IDLE, `start`=1 is accepted when `dest_addr`≠3 and `buf_count`≥`pkt_len`.
  - On acceptance, latch addr, len and corrupt, and compute header = {len, addr}.
  - Parity accumulator is loaded with the header. Go to HEADER.
- **Start rejection.** `start` with addr=3 or an insufficient count: pulse `cmd_err`, stay in IDLE, buffer untouched.
- `start` outside IDLE is ignored, with no `cmd_err`.
- **Byte advance.** A byte "advances" on any edge where `busy`=0 in HEADER, PAYLOAD or PARITY.
- **HEADER.** `data_out`=header, `pkt_valid`=1. On advance: go to PAYLOAD if len>0, otherwise to PARITY.
- **PAYLOAD.** `data_out`=buffer head, `pkt_valid`=1. On advance:
  - pop the buffer and XOR the byte into the accumulator;
  - decrement the remaining count;
  - after the last byte, go to PARITY.
- **PARITY.** `data_out`=accumulator ^ {7'b0, corrupt}, `pkt_valid`=0. On advance: pulse `done` and go to GAP.
- **GAP.** One cycle with `pkt_valid`=0 and `data_out`=0, then IDLE. Consecutive packets are therefore at least one cycle apart.
- **Buffer.** FIFO of DEPTH×8.
  - A write when full is dropped.
  - Simultaneous write and pop is legal; the count is unchanged.
  - Writes are accepted in every state.
- Bytes beyond `pkt_len` stay in the buffer for the next packet.
- **Reset.** All of the following return to 0 on the next edge:
  - state = IDLE, buffer flushed;
  - `data_out`, `pkt_valid`, `tx_active`, `done`, `cmd_err`, `buf_count`, `buf_full`.
- Reset in the middle of a packet abandons it and emits no parity byte.

## Timing
- All outputs are registered.
- Start accepted at edge N: the header appears on `data_out` with `pkt_valid`=1 from cycle N+1.
- Without busy, one byte per cycle. A packet of L bytes occupies L+2 cycles (header, payload, parity) plus 1 GAP cycle.
- `busy` sampled high at an edge: `data_out`, `pkt_valid` and state hold unchanged, with no pop.
- `done` is high during the GAP cycle.
- `tx_active` rises with the header cycle and falls when IDLE is entered.
- `cmd_err` is high in cycle N+1 after the rejected start.
- `buf_count` updates one cycle after `wr_en` or a pop.

## Structure
- Shared package `router_pkg` holds:
  - state enum `tx_state_t`;
  - `ADDR_INVALID`=2'b11;
  - `MAX_LEN`=63;
  - the header-pack function {len[5:0], addr[1:0]}.
- One sub-module, `router_tx_fifo`: synchronous DEPTH×8 FIFO with `wr_en`/`rd_en`/`count`/`full`/`empty` and the same clock and reset.
- The FSM and parity accumulator live in the top level.

## Test plan
- **Basic packet.** Write 0x11, 0x22, 0x33; start with addr=1, len=3; `busy`=0. Required: `data_out` 0x0D, 0x11, 0x22, 0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0. `done` in GAP, `buf_count` back to 0.
- **Zero length.** Start with addr=2, len=0, empty buffer. Required: header 0x02, then parity 0x02; total 3 cycles to IDLE.
- **Illegal or unfunded start.** Start with addr=3, then start with len=5 and `buf_count`=2. Required: two `cmd_err` pulses, no `pkt_valid`, `buf_count` stays 2.
- **Back-pressure.** Basic packet with `busy` high for 3 cycles during the second payload byte. Required: 0x22 held for 4 cycles, no byte skipped or duplicated, parity still 0x0D.
- **Error injection.** Basic packet with `corrupt_parity`=1. Required: parity byte 0x0C.
- **Reset mid-packet.** Assert `reset` during PAYLOAD. Required: next cycle `pkt_valid`=0, `data_out`=0, `buf_count`=0; a following fresh packet is emitted correctly.
